// File: rtl/gfx_pkg.sv
// Shared graphics types: FSM states, the latched line command and
// the default screen geometry used by the line rasteriser.
package gfx_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int COLOUR_W_DEF = 8;
  localparam int H_RES_DEF    = 800;
  localparam int V_RES_DEF    = 480;
  localparam int ADDR_W_DEF   = 18;

  localparam int LC_COORD_W  = COORD_W_DEF;
  localparam int LC_COLOUR_W = COLOUR_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STEP,
    DONE
  } state_e;

  typedef struct packed {
    logic [LC_COORD_W-1:0]  x1;
    logic [LC_COORD_W-1:0]  y1;
    logic [LC_COORD_W-1:0]  x2;
    logic [LC_COORD_W-1:0]  y2;
    logic [LC_COLOUR_W-1:0] colour;
  } line_cmd_t;

  // Two extra bits hold the sign and the 2*err headroom.
  function automatic int err_w(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/line_draw_engine_if.sv
// Command and pixel-write handshake bundle of the line engine.
// master = command/arbiter side, slave = the engine.
interface line_draw_engine_if
  import gfx_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
);

  logic                Cmd_Valid;
  logic                Cmd_Ready;
  logic [COORD_W-1:0]  Cmd_X1;
  logic [COORD_W-1:0]  Cmd_Y1;
  logic [COORD_W-1:0]  Cmd_X2;
  logic [COORD_W-1:0]  Cmd_Y2;
  logic [COLOUR_W-1:0] Cmd_Colour;
  logic                Abort;
  logic                Pix_Valid;
  logic                Pix_Ready;
  logic [COORD_W-1:0]  Pix_X;
  logic [COORD_W-1:0]  Pix_Y;
  logic [ADDR_W-1:0]   Pix_Addr;
  logic [15:0]         Pix_Data;
  logic                Pix_UDS_L;
  logic                Pix_LDS_L;
  logic                Busy;
  logic                Done;

  modport master (
    output Cmd_Valid, Cmd_X1, Cmd_Y1,
    output Cmd_X2, Cmd_Y2, Cmd_Colour,
    output Abort, Pix_Ready,
    input  Cmd_Ready, Pix_Valid,
    input  Pix_X, Pix_Y, Pix_Addr,
    input  Pix_Data, Pix_UDS_L, Pix_LDS_L,
    input  Busy, Done
  );

  modport slave (
    input  Cmd_Valid, Cmd_X1, Cmd_Y1,
    input  Cmd_X2, Cmd_Y2, Cmd_Colour,
    input  Abort, Pix_Ready,
    output Cmd_Ready, Pix_Valid,
    output Pix_X, Pix_Y, Pix_Addr,
    output Pix_Data, Pix_UDS_L, Pix_LDS_L,
    output Busy, Done
  );

endinterface

// File: rtl/gfx_pix_addr.sv
// Pixel (x,y) to 16-bit SRAM word address plus active-low byte
// strobes; even x is the upper byte, odd x the lower byte.
module gfx_pix_addr
  import gfx_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int H_RES   = H_RES_DEF
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               en,
  output logic [ADDR_W-1:0]  addr,
  output logic               uds_l,
  output logic               lds_l
);

  localparam int LW = ADDR_W + 1;

  logic [LW-1:0] lin;

  assign lin   = LW'(y) * LW'(H_RES) + LW'(x);
  assign addr  = ADDR_W'(lin >> 1);
  assign uds_l = !(en && !x[0]);
  assign lds_l = !(en && x[0]);

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser, any octant, one pixel write per step.
// Define LINE_CLIP_EN to suppress writes for off-screen steps.
module line_draw_engine
  import gfx_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int COLOUR_W = COLOUR_W_DEF,
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  line_draw_engine_if.slave bus
);

  localparam int EW = err_w(COORD_W);

`ifdef LINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic [COORD_W:0] X_LIM =
    (COORD_W+1)'(H_RES);
  localparam logic [COORD_W:0] Y_LIM =
    (COORD_W+1)'(V_RES);

  typedef logic signed [EW-1:0] err_t;

  state_e             state_q, state_d;
  line_cmd_t          cmd_q, cmd_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  err_t               dx_q, dx_d;
  err_t               dy_q, dy_d;
  err_t               err_q, err_d;
  logic               sx_q, sx_d;
  logic               sy_q, sy_d;
  logic               rdy_q, rdy_d;

  logic [COORD_W-1:0]  x1, y1, x2, y2;
  logic [COLOUR_W-1:0] colour;
  err_t                ex1, ey1, ex2, ey2;
  logic signed [EW:0]  e2, dx_ext, dy_ext;
  logic                on_scr, show, adv, at_end;

  assign x1     = COORD_W'(cmd_q.x1);
  assign y1     = COORD_W'(cmd_q.y1);
  assign x2     = COORD_W'(cmd_q.x2);
  assign y2     = COORD_W'(cmd_q.y2);
  assign colour = COLOUR_W'(cmd_q.colour);

  assign ex1 = $signed({2'b00, x1});
  assign ey1 = $signed({2'b00, y1});
  assign ex2 = $signed({2'b00, x2});
  assign ey2 = $signed({2'b00, y2});

  assign e2     = $signed({err_q, 1'b0});
  assign dx_ext = $signed({dx_q[EW-1], dx_q});
  assign dy_ext = $signed({dy_q[EW-1], dy_q});

  assign on_scr = ({1'b0, x_q} < X_LIM) &&
                  ({1'b0, y_q} < Y_LIM);
  assign show   = (state_q == STEP) &&
                  (!CLIP || on_scr);
  // A clipped step never waits for the arbiter.
  assign adv    = show ? bus.Pix_Ready : 1'b1;
  assign at_end = (x_q == x2) && (y_q == y2);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    rdy_d   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.Cmd_Valid && rdy_q) begin
          cmd_d.x1     = LC_COORD_W'(bus.Cmd_X1);
          cmd_d.y1     = LC_COORD_W'(bus.Cmd_Y1);
          cmd_d.x2     = LC_COORD_W'(bus.Cmd_X2);
          cmd_d.y2     = LC_COORD_W'(bus.Cmd_Y2);
          cmd_d.colour = LC_COLOUR_W'(bus.Cmd_Colour);
          x_d          = bus.Cmd_X1;
          y_d          = bus.Cmd_Y1;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        sx_d    = x2 < x1;
        sy_d    = y2 < y1;
        dx_d    = sx_d ? ex1 - ex2 : ex2 - ex1;
        dy_d    = sy_d ? ey2 - ey1 : ey1 - ey2;
        err_d   = dx_d + dy_d;
        state_d = bus.Abort ? DONE : STEP;
      end
      STEP: begin
        if (bus.Abort) begin
          state_d = DONE;
        end else if (adv) begin
          if (at_end) begin
            state_d = DONE;
          end else begin
            if (e2 >= dy_ext) begin
              err_d = err_d + dy_q;
              x_d   = sx_q ? x_q - COORD_W'(1)
                           : x_q + COORD_W'(1);
            end
            if (e2 <= dx_ext) begin
              err_d = err_d + dx_q;
              y_d   = sy_q ? y_q - COORD_W'(1)
                           : y_q + COORD_W'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      rdy_q   <= rdy_d;
    end
  end

  assign bus.Cmd_Ready = (state_q == IDLE) && rdy_q;
  assign bus.Pix_Valid = show;
  assign bus.Pix_X     = x_q;
  assign bus.Pix_Y     = y_q;
  assign bus.Pix_Data  = 16'({colour, colour});
  assign bus.Busy      = state_q != IDLE;
  assign bus.Done      = state_q == DONE;

  gfx_pix_addr #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .H_RES   (H_RES)
  ) u_pix_addr (
    .x     (x_q),
    .y     (y_q),
    .en    (show),
    .addr  (bus.Pix_Addr),
    .uds_l (bus.Pix_UDS_L),
    .lds_l (bus.Pix_LDS_L)
  );

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed bench for line_draw_engine: reset, octants, stalls,
// abort, degenerate line and the off-screen edge case.
module tb_line_draw_engine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_draw_engine_if #(
    .COORD_W(10), .COLOUR_W(8), .ADDR_W(18)
  ) bus ();

  line_draw_engine #(
    .COORD_W(10), .COLOUR_W(8),
    .H_RES(800), .V_RES(480), .ADDR_W(18)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_run;
  int n_fail;
  int xs[$];
  int ys[$];
  int first_v, done_cyc, abort_cyc;
  logic [31:0] f_addr, f_data;
  logic        f_uds, f_lds;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int x1, input int y1,
                          input int x2, input int y2,
                          input int col);
    int w;
    w = 0;
    @(negedge clk);
    bus.Cmd_X1     = 10'(x1);
    bus.Cmd_Y1     = 10'(y1);
    bus.Cmd_X2     = 10'(x2);
    bus.Cmd_Y2     = 10'(y2);
    bus.Cmd_Colour = 8'(col);
    bus.Cmd_Valid  = 1'b1;
    while (!bus.Cmd_Ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept", 32'(bus.Cmd_Ready), 1);
    @(posedge clk);
    #1;
    bus.Cmd_Valid = 1'b0;
  endtask

  task automatic run_line(input int x1, input int y1,
                          input int x2, input int y2,
                          input int col, input bit rnd,
                          input int abort_at);
    bit   seen, stall;
    logic [9:0]  hx, hy;
    logic [17:0] ha;
    xs.delete();
    ys.delete();
    first_v   = -1;
    done_cyc  = -1;
    abort_cyc = -1;
    seen      = 1'b0;
    stall     = 1'b0;
    hx = '0; hy = '0; ha = '0;
    send_cmd(x1, y1, x2, y2, col);
    for (int cyc = 1; cyc < 3000 && !seen; cyc++) begin
      @(negedge clk);
      bus.Abort = 1'b0;
      if (stall) begin
        chk("hold_valid", 32'(bus.Pix_Valid), 1);
        chk("hold_x", 32'(bus.Pix_X), 32'(hx));
        chk("hold_y", 32'(bus.Pix_Y), 32'(hy));
        chk("hold_addr", 32'(bus.Pix_Addr), 32'(ha));
      end
      bus.Pix_Ready = rnd ? 1'($urandom_range(0, 1))
                          : 1'b1;
      if (bus.Done) begin
        seen     = 1'b1;
        done_cyc = cyc;
        chk("busy_in_done", 32'(bus.Busy), 1);
      end
      if (bus.Pix_Valid && first_v < 0) first_v = cyc;
      stall = bus.Pix_Valid && !bus.Pix_Ready;
      hx = bus.Pix_X;
      hy = bus.Pix_Y;
      ha = bus.Pix_Addr;
      if (bus.Pix_Valid && bus.Pix_Ready) begin
        xs.push_back(int'(bus.Pix_X));
        ys.push_back(int'(bus.Pix_Y));
        if (xs.size() == 1) begin
          f_addr = 32'(bus.Pix_Addr);
          f_data = 32'(bus.Pix_Data);
          f_uds  = bus.Pix_UDS_L;
          f_lds  = bus.Pix_LDS_L;
        end
        if (abort_at > 0 && xs.size() == abort_at) begin
          bus.Abort = 1'b1;
          abort_cyc = cyc;
        end
      end
    end
    chk("done_seen", 32'(seen), 1);
    @(negedge clk);
    bus.Abort     = 1'b0;
    bus.Pix_Ready = 1'b1;
    chk("done_one_pulse", 32'(bus.Done), 0);
    chk("busy_off", 32'(bus.Busy), 0);
    chk("ready_back", 32'(bus.Cmd_Ready), 1);
  endtask

  initial begin
    int bad;
    n_run  = 0;
    n_fail = 0;
    rst            = 1'b1;
    bus.Cmd_Valid  = 1'b0;
    bus.Cmd_X1     = '0;
    bus.Cmd_Y1     = '0;
    bus.Cmd_X2     = '0;
    bus.Cmd_Y2     = '0;
    bus.Cmd_Colour = '0;
    bus.Abort      = 1'b0;
    bus.Pix_Ready  = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.Cmd_Ready), 0);
    chk("rst_valid", 32'(bus.Pix_Valid), 0);
    chk("rst_busy", 32'(bus.Busy), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_addr", 32'(bus.Pix_Addr), 0);
    chk("rst_data", 32'(bus.Pix_Data), 0);
    chk("rst_uds", 32'(bus.Pix_UDS_L), 1);
    chk("rst_lds", 32'(bus.Pix_LDS_L), 1);
    rst = 1'b0;
    #1;
    chk("rel_ready_early", 32'(bus.Cmd_Ready), 0);
    @(negedge clk);
    chk("rel_ready", 32'(bus.Cmd_Ready), 1);

    // 45-degree diagonal
    run_line(100, 100, 150, 150, 2, 1'b0, 0);
    chk("c2_count", 32'(xs.size()), 51);
    bad = 0;
    foreach (xs[i])
      if (xs[i] != 100 + i || ys[i] != 100 + i) bad++;
    chk("c2_diag", 32'(bad), 0);
    chk("c2_addr", f_addr, 40050);
    chk("c2_uds", 32'(f_uds), 0);
    chk("c2_lds", 32'(f_lds), 1);
    chk("c2_data", f_data, 32'h0202);
    chk("c2_latency", 32'(first_v), 2);
    if (xs.size() > 0) begin
      chk("c2_last_x", 32'(xs[$]), 150);
      chk("c2_last_y", 32'(ys[$]), 150);
    end

    // shallow x-major line
    run_line(150, 300, 750, 450, 5, 1'b0, 0);
    chk("c3_count", 32'(xs.size()), 601);
    bad = 0;
    foreach (xs[i]) begin
      if (xs[i] != 150 + i) bad++;
      if (ys[i] < 300 || ys[i] > 450) bad++;
      if (i > 0 && (ys[i] < ys[i-1] ||
                    ys[i] > ys[i-1] + 1)) bad++;
    end
    chk("c3_walk", 32'(bad), 0);
    if (xs.size() > 0) begin
      chk("c3_last_x", 32'(xs[$]), 750);
      chk("c3_last_y", 32'(ys[$]), 450);
    end

    // vertical, upward
    run_line(10, 20, 10, 5, 3, 1'b0, 0);
    chk("c4_count", 32'(xs.size()), 16);
    bad = 0;
    foreach (xs[i])
      if (xs[i] != 10 || ys[i] != 20 - i) bad++;
    chk("c4_vert", 32'(bad), 0);

    // degenerate single point, odd x
    run_line(7, 7, 7, 7, 9, 1'b0, 0);
    chk("c4_pt_count", 32'(xs.size()), 1);
    chk("c4_pt_addr", f_addr, 2803);
    chk("c4_pt_uds", 32'(f_uds), 1);
    chk("c4_pt_lds", 32'(f_lds), 0);
    chk("c4_pt_data", f_data, 32'h0909);
    chk("c4_pt_done", 32'(done_cyc - first_v), 1);

    // random back-pressure
    run_line(100, 100, 150, 150, 2, 1'b1, 0);
    chk("c5_count", 32'(xs.size()), 51);
    bad = 0;
    foreach (xs[i])
      if (xs[i] != 100 + i || ys[i] != 100 + i) bad++;
    chk("c5_diag", 32'(bad), 0);

    // abort on the 5th handshake
    run_line(150, 300, 750, 450, 5, 1'b0, 5);
    chk("c6_count", 32'(xs.size()), 5);
    chk("c6_done_lat", 32'(done_cyc - abort_cyc), 1);
    if (xs.size() > 0)
      chk("c6_last_x", 32'(xs[$]), 154);

    // line crossing the right screen edge
    run_line(790, 10, 810, 10, 1, 1'b0, 0);
`ifdef LINE_CLIP_EN
    chk("clip_count", 32'(xs.size()), 10);
    if (xs.size() > 0)
      chk("clip_last_x", 32'(xs[$]), 799);
`else
    chk("edge_count", 32'(xs.size()), 21);
    if (xs.size() > 0)
      chk("edge_last_x", 32'(xs[$]), 810);
`endif
    chk("edge_steps", 32'(done_cyc - first_v), 21);

    // reset in the middle of a line
    send_cmd(100, 100, 150, 150, 2);
    repeat (5) @(negedge clk);
    chk("mid_valid_pre", 32'(bus.Pix_Valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.Pix_Valid), 0);
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_addr", 32'(bus.Pix_Addr), 0);
    chk("mid_rst_uds", 32'(bus.Pix_UDS_L), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", 32'(bus.Cmd_Ready), 1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.Pix_Valid || bus.Busy) bad++;
    end
    chk("mid_no_pixels", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
